// File: rtl/fetch_pc_ctrl_pkg.sv
// Shared fetch-path definitions: datapath width, PC step, reset PC and fetch FSM states.
package riscv_pkg;

  localparam int          XLEN         = 32;
  localparam int          PC_STEP      = 4;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_ERR  = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/fetch_pc_ctrl_if.sv
// Fetch bus bundle: redirect input, imem request/response channels and decode handoff.
interface fetch_pc_ctrl_if #(
  parameter int XLEN = riscv_pkg::XLEN
);
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;
  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_req_ready;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            inst_valid;
  logic [31:0]     inst_data;
  logic [XLEN-1:0] inst_pc;
  logic            id_ready;

  // master: the fetch controller; slave: pc mux, imem and decode around it
  modport master (
    input  redirect_valid, redirect_target, imem_req_ready, imem_rsp_valid,
           imem_rsp_data, id_ready,
    output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc
  );

  modport slave (
    output redirect_valid, redirect_target, imem_req_ready, imem_rsp_valid,
           imem_rsp_data, id_ready,
    input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc
  );
endinterface

// File: rtl/fetch_pc_ctrl_pc_register.sv
// Architectural PC register: loads either the sequential pc+step or a redirect target.
module pc_register
  import riscv_pkg::*;
#(
  parameter int              XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic            sel_redirect_i,
  input  logic [XLEN-1:0] target_i,
  output logic [XLEN-1:0] pc_o
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;

  // sequential step wraps naturally modulo 2^XLEN
  assign pc_d = sel_redirect_i ? target_i : pc_q + XLEN'(PC_STEP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else if (load_i) begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Single-outstanding instruction fetch controller with redirect flush.
// Optional misaligned-redirect trap enabled by FETCH_MISALIGN_TRAP_EN.
module fetch_pc_ctrl
  import riscv_pkg::*;
#(
  parameter int              XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
  input  logic clk,
  input  logic rst,
  fetch_pc_ctrl_if.master bus
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic misalign_err
`endif
);

  fetch_state_e    state_q;
  logic            drop_q;
  logic            req_valid_q;
  logic            inst_valid_q;
  logic [31:0]     inst_data_q;
  logic [XLEN-1:0] inst_pc_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] target_aligned;
  logic            redirect_act;
  logic            misalign_hit;
  logic            pc_load;

  assign redirect_act   = bus.redirect_valid && (state_q == S_REQ || state_q == S_WAIT ||
                                                 state_q == S_HOLD);
  assign target_aligned = bus.redirect_target & ~{{(XLEN-2){1'b0}}, 2'b11};

`ifdef FETCH_MISALIGN_TRAP_EN
  logic err_q;
  assign misalign_hit = redirect_act && (bus.redirect_target[1:0] != 2'b00);
  assign misalign_err = err_q;
`else
  assign misalign_hit = 1'b0;
`endif

  // redirect wins over the sequential increment from an accepted response
  assign pc_load = (redirect_act && !misalign_hit) ||
                   (state_q == S_WAIT && bus.imem_rsp_valid && !drop_q && !redirect_act);

  pc_register #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk            (clk),
    .rst            (rst),
    .load_i         (pc_load),
    .sel_redirect_i (redirect_act),
    .target_i       (target_aligned),
    .pc_o           (pc_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      drop_q       <= 1'b0;
      req_valid_q  <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_data_q  <= '0;
      inst_pc_q    <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      err_q        <= 1'b0;
`endif
    end else if (misalign_hit) begin
      state_q      <= S_ERR;
      drop_q       <= 1'b0;
      req_valid_q  <= 1'b0;
      inst_valid_q <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      err_q        <= 1'b1;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q     <= S_REQ;
          req_valid_q <= 1'b1;
        end
        S_REQ: begin
          if (bus.imem_req_ready) begin
            state_q     <= S_WAIT;
            req_valid_q <= 1'b0;
            drop_q      <= redirect_act;
          end
        end
        S_WAIT: begin
          if (bus.imem_rsp_valid) begin
            if (redirect_act || drop_q) begin
              state_q     <= S_REQ;
              req_valid_q <= 1'b1;
              drop_q      <= 1'b0;
            end else begin
              state_q      <= S_HOLD;
              inst_valid_q <= 1'b1;
              inst_data_q  <= bus.imem_rsp_data;
              inst_pc_q    <= pc_q;
            end
          end else if (redirect_act) begin
            drop_q <= 1'b1;
          end
        end
        S_HOLD: begin
          if (redirect_act || bus.id_ready) begin
            state_q      <= S_REQ;
            req_valid_q  <= 1'b1;
            inst_valid_q <= 1'b0;
          end
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        S_ERR: begin
          state_q <= S_ERR;
        end
`endif
        default: begin
          state_q      <= S_IDLE;
          req_valid_q  <= 1'b0;
          inst_valid_q <= 1'b0;
          drop_q       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_req_valid = req_valid_q;
  assign bus.imem_req_addr  = pc_q;
  assign bus.inst_valid     = inst_valid_q;
  assign bus.inst_data      = inst_data_q;
  assign bus.inst_pc        = inst_pc_q;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed bench for fetch_pc_ctrl; covers FETCH_MISALIGN_TRAP_EN builds as well.
module tb_fetch_pc_ctrl;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_bad;

  fetch_pc_ctrl_if #(.XLEN(32)) bus ();

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign_err;
`endif

  fetch_pc_ctrl #(
    .XLEN     (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .misalign_err (misalign_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // waits (bounded) until a request is presented, then checks its address
  task automatic expect_req(input string tag, input logic [31:0] addr);
    int n;
    n = 0;
    while (bus.imem_req_valid !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    chk({tag, "_valid"}, {31'd0, bus.imem_req_valid}, 32'd1);
    chk({tag, "_addr"}, bus.imem_req_addr, addr);
  endtask

  // handshake the pending request, return a word next cycle, end in S_HOLD
  task automatic fetch_word(input logic [31:0] word);
    bus.imem_req_ready = 1'b1;
    step();
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = word;
    step();
    bus.imem_rsp_valid = 1'b0;
  endtask

  task automatic check_inst(input string tag, input logic [31:0] pc, input logic [31:0] word);
    chk({tag, "_ivalid"}, {31'd0, bus.inst_valid}, 32'd1);
    chk({tag, "_ipc"}, bus.inst_pc, pc);
    chk({tag, "_idata"}, bus.inst_data, word);
  endtask

  initial begin
    n_chk = 0;
    n_bad = 0;
    rst = 1'b1;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = '0;
    bus.imem_req_ready  = 1'b0;
    bus.imem_rsp_valid  = 1'b0;
    bus.imem_rsp_data   = '0;
    bus.id_ready        = 1'b0;
    step();
    step();
    chk("rst_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
    chk("rst_req_addr", bus.imem_req_addr, 32'h0);
    chk("rst_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
    chk("rst_inst_data", bus.inst_data, 32'h0);
    chk("rst_inst_pc", bus.inst_pc, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("rst_err", {31'd0, misalign_err}, 32'd0);
`endif

    // first fetch: one idle cycle, then request at RESET_PC
    rst = 1'b0;
    chk("idle_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
    step();
    chk("first_req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
    chk("first_req_addr", bus.imem_req_addr, 32'h0);
    bus.imem_req_ready = 1'b1;
    step();
    chk("wait_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'h0050_0093;
    step();
    bus.imem_rsp_valid = 1'b0;
    check_inst("f0", 32'h0, 32'h0050_0093);
    bus.id_ready = 1'b1;
    step();
    bus.id_ready = 1'b0;
    chk("f0_consumed", {31'd0, bus.inst_valid}, 32'd0);
    expect_req("f1_req", 32'h4);

    // decode stall holds the buffer steady
    fetch_word(32'h1111_2222);
    for (int i = 0; i < 5; i++) begin
      check_inst("stall", 32'h4, 32'h1111_2222);
      chk("stall_no_req", {31'd0, bus.imem_req_valid}, 32'd0);
      step();
    end
    bus.id_ready = 1'b1;
    step();
    bus.id_ready = 1'b0;
    expect_req("f2_req", 32'h8);

    // redirect during S_WAIT; late response must be dropped
    bus.imem_req_ready = 1'b1;
    step();
    bus.imem_req_ready  = 1'b0;
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h100;
    step();
    bus.redirect_valid = 1'b0;
    step();
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'hDEAD_BEEF;
    step();
    bus.imem_rsp_valid = 1'b0;
    chk("drop_ivalid", {31'd0, bus.inst_valid}, 32'd0);
    chk("drop_req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
    chk("drop_req_addr", bus.imem_req_addr, 32'h100);

    // redirect in S_HOLD beats a same-cycle id_ready
    fetch_word(32'hAAAA_0001);
    check_inst("f100", 32'h100, 32'hAAAA_0001);
    bus.id_ready        = 1'b1;
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h200;
    step();
    bus.id_ready       = 1'b0;
    bus.redirect_valid = 1'b0;
    chk("hold_redir_ivalid", {31'd0, bus.inst_valid}, 32'd0);
    expect_req("hold_redir_req", 32'h200);
    fetch_word(32'hAAAA_0002);
    check_inst("f200", 32'h200, 32'hAAAA_0002);
    bus.id_ready = 1'b1;
    step();
    bus.id_ready = 1'b0;
    expect_req("f204_req", 32'h204);

    // redirect in S_REQ without handshake, then pc wrap
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'hFFFF_FFFC;
    step();
    bus.redirect_valid = 1'b0;
    expect_req("top_req", 32'hFFFF_FFFC);
    fetch_word(32'hCAFE_F00D);
    check_inst("ftop", 32'hFFFF_FFFC, 32'hCAFE_F00D);
    bus.id_ready = 1'b1;
    step();
    bus.id_ready = 1'b0;
    expect_req("wrap_req", 32'h0);

    // redirect together with the request handshake: response is dropped
    bus.imem_req_ready  = 1'b1;
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h300;
    step();
    bus.imem_req_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    chk("req_redir_wait", {31'd0, bus.imem_req_valid}, 32'd0);
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'h1234_5678;
    step();
    bus.imem_rsp_valid = 1'b0;
    chk("req_redir_ivalid", {31'd0, bus.inst_valid}, 32'd0);
    chk("req_redir_addr", bus.imem_req_addr, 32'h300);
    chk("req_redir_valid", {31'd0, bus.imem_req_valid}, 32'd1);

    // misaligned redirect target
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h102;
    step();
    bus.redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    for (int i = 0; i < 3; i++) begin
      chk("mis_err", {31'd0, misalign_err}, 32'd1);
      chk("mis_no_req", {31'd0, bus.imem_req_valid}, 32'd0);
      chk("mis_ivalid", {31'd0, bus.inst_valid}, 32'd0);
      step();
    end
`else
    chk("mis_req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
    chk("mis_req_addr", bus.imem_req_addr, 32'h100);
    bus.imem_req_ready = 1'b1;
    step();
    bus.imem_req_ready = 1'b0;
`endif

    // reset mid-operation; a stray response afterwards is ignored
    rst = 1'b1;
    step();
    chk("mid_rst_addr", bus.imem_req_addr, 32'h0);
    rst = 1'b0;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'h5555_AAAA;
    step();
    step();
    bus.imem_rsp_valid = 1'b0;
    chk("post_rst_ivalid", {31'd0, bus.inst_valid}, 32'd0);
    chk("post_rst_req", {31'd0, bus.imem_req_valid}, 32'd1);
    chk("post_rst_addr", bus.imem_req_addr, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("post_rst_err", {31'd0, misalign_err}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
